// File: rtl/vid_timing_pkg.sv
// Mode table, timing record and helpers shared by the multi-mode raster timing generator.
package vid_timing_pkg;

  typedef enum logic [1:0] {
    MODE_640X480   = 2'd0,
    MODE_1280X720  = 2'd1,
    MODE_1920X1080 = 2'd2
  } mode_t;

  localparam logic [1:0] MODE_RESERVED = 2'd3;

  // sync_pol: 1 = sync asserted high, 0 = sync asserted low
  typedef struct packed {
    logic [11:0] h_act;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_act;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic        sync_pol;
  } timing_t;

  localparam timing_t MODE_TBL [3] = '{
    '{12'd640,  12'd16,  12'd96, 12'd48,  12'd480,  12'd10, 12'd2, 12'd33, 1'b0},
    '{12'd1280, 12'd110, 12'd40, 12'd220, 12'd720,  12'd5,  12'd5, 12'd20, 1'b1},
    '{12'd1920, 12'd88,  12'd44, 12'd148, 12'd1080, 12'd4,  12'd5, 12'd36, 1'b1}
  };

  function automatic logic [11:0] h_total(input timing_t t);
    return t.h_act + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [11:0] v_total(input timing_t t);
    return t.v_act + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage

// File: rtl/vid_timing_gen.sv
// Multi-mode raster timing generator; mode changes are taken only at the frame boundary.
// Defining VID_TIMING_FRAME_CNT_EN adds the 16-bit frame_cnt output.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int CORDW = 12
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [1:0]       mode_sel,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line_start,
  output logic             frame_start,
  output logic [1:0]       mode_active
`ifdef VID_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  if (CORDW < 12) begin : g_cordw_chk
    $error("vid_timing_gen: CORDW must be >= 12");
  end

  localparam logic [CORDW-1:0] ZERO = {CORDW{1'b0}};
  localparam logic [CORDW-1:0] ONE  = {{(CORDW-1){1'b0}}, 1'b1};

  mode_t            mode_cur;
  mode_t            mode_pend;
  timing_t          tm;
  logic [CORDW-1:0] hc;
  logic [CORDW-1:0] vc;
  logic [CORDW-1:0] h_act;
  logic [CORDW-1:0] v_act;
  logic [CORDW-1:0] h_last;
  logic [CORDW-1:0] v_last;
  logic [CORDW-1:0] hs_beg;
  logic [CORDW-1:0] hs_end;
  logic [CORDW-1:0] vs_beg;
  logic [CORDW-1:0] vs_end;
  logic             line_end;
  logic             frame_end;
  logic             hs_on;
  logic             vs_on;
  logic             hs_lvl;
  logic             vs_lvl;
  logic             de_nxt;

  // Timing record of the mode currently being generated
  always_comb begin
    tm = MODE_TBL[0];
    case (mode_cur)
      MODE_640X480:   tm = MODE_TBL[0];
      MODE_1280X720:  tm = MODE_TBL[1];
      MODE_1920X1080: tm = MODE_TBL[2];
      default:        tm = MODE_TBL[0];
    endcase
  end

  // Boundary and window decode of the raw counters
  always_comb begin
    h_act     = CORDW'(tm.h_act);
    v_act     = CORDW'(tm.v_act);
    h_last    = CORDW'(h_total(tm)) - ONE;
    v_last    = CORDW'(v_total(tm)) - ONE;
    hs_beg    = CORDW'(tm.h_act) + CORDW'(tm.h_fp);
    hs_end    = hs_beg + CORDW'(tm.h_sync);
    vs_beg    = CORDW'(tm.v_act) + CORDW'(tm.v_fp);
    vs_end    = vs_beg + CORDW'(tm.v_sync);
    line_end  = (hc == h_last);
    frame_end = line_end && (vc == v_last);
    hs_on     = (hc >= hs_beg) && (hc < hs_end);
    vs_on     = (vc >= vs_beg) && (vc < vs_end);
    hs_lvl    = tm.sync_pol ? hs_on : ~hs_on;
    vs_lvl    = tm.sync_pol ? vs_on : ~vs_on;
    de_nxt    = (hc < h_act) && (vc < v_act);
  end

  // Raster counters and mode latch; active mode only moves at the frame boundary
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      hc        <= ZERO;
      vc        <= ZERO;
      mode_cur  <= MODE_640X480;
      mode_pend <= MODE_640X480;
    end else begin
      if (mode_sel != MODE_RESERVED) begin
        mode_pend <= mode_t'(mode_sel);
      end
      if (line_end) begin
        hc <= ZERO;
        if (frame_end) begin
          vc       <= ZERO;
          mode_cur <= mode_pend;
        end else begin
          vc <= vc + ONE;
        end
      end else begin
        hc <= hc + ONE;
      end
    end
  end

  // Registered outputs, one cycle behind the counters and mutually aligned
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      sx          <= ZERO;
      sy          <= ZERO;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_active <= 2'd0;
    end else begin
      sx          <= hc;
      sy          <= vc;
      hsync       <= hs_lvl;
      vsync       <= vs_lvl;
      de          <= de_nxt;
      line_start  <= (hc == ZERO);
      frame_start <= (hc == ZERO) && (vc == ZERO);
      mode_active <= mode_cur;
    end
  end

`ifdef VID_TIMING_FRAME_CNT_EN
  logic cnt_armed;

  // Frame counter; the first frame after reset is reported as frame 0
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      frame_cnt <= 16'd0;
      cnt_armed <= 1'b0;
    end else if ((hc == ZERO) && (vc == ZERO)) begin
      if (cnt_armed) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      cnt_armed <= 1'b1;
    end
  end
`endif

endmodule
